coin_deposit: RTL and testbench



---
 rtl/vm_pkg.sv | 33 +++
 rtl/coin_deposit_if.sv | 32 +++
 rtl/coin_deposit_sat_add.sv | 24 ++
 rtl/coin_deposit.sv | 137 +++++++++++++
 tb/tb_coin_deposit.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/vm_pkg.sv
// Shared vending-machine money definitions: widths, coin values and FSM state codes.
// Reused by the deposit, owner withdrawal and display blocks.
package vm_pkg;

  localparam int W = 11;

  localparam logic [W-1:0] MAX   = {W{1'b1}};
  localparam logic [W-1:0] ZERO  = 11'd0;
  localparam logic [W-1:0] COIN0 = 11'd1;
  localparam logic [W-1:0] COIN1 = 11'd5;
  localparam logic [W-1:0] COIN2 = 11'd10;
  localparam logic [W-1:0] COIN3 = 11'd25;

  typedef logic [W-1:0] money_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_VEND    = 2'd2;
  localparam logic [1:0] ST_CHANGE  = 2'd3;

  function automatic money_t coin_value(input logic [1:0] coin_type);
    money_t v;
    case (coin_type)
      2'd0:    v = COIN0;
      2'd1:    v = COIN1;
      2'd2:    v = COIN2;
      2'd3:    v = COIN3;
      default: v = COIN0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_deposit_if.sv
// Customer/owner-facing signal bundle of the coin deposit block.
// master drives the strobes; slave is the deposit block itself.
interface coin_deposit_if;
  import vm_pkg::*;

  logic       mode;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       vend_req;
  money_t     price;
  logic       cancel;
  logic       change_ack;
  logic       owner_take;
  money_t     credit;
  money_t     machine_money;
  logic       vend_ok;
  logic       coin_reject;
  money_t     change;
  logic       change_valid;
  logic       redlight;

  modport master (
    output mode, coin_valid, coin_type, vend_req, price, cancel, change_ack, owner_take,
    input  credit, machine_money, vend_ok, coin_reject, change, change_valid, redlight
  );

  modport slave (
    input  mode, coin_valid, coin_type, vend_req, price, cancel, change_ack, owner_take,
    output credit, machine_money, vend_ok, coin_reject, change, change_valid, redlight
  );

endinterface

// File: rtl/coin_deposit_sat_add.sv
// W-bit adder with overflow flag; the sum saturates at MAX so it never wraps.
module money_sat_add
  import vm_pkg::*;
(
  input  money_t a,
  input  money_t b,
  output money_t sum,
  output logic   ovf
);

  logic [W:0] wide_s;

  // Widened add, then clamp on carry-out.
  always_comb begin
    wide_s = {1'b0, a} + {1'b0, b};
    ovf    = wide_s[W];
    if (wide_s[W]) begin
      sum = MAX;
    end else begin
      sum = wide_s[W-1:0];
    end
  end

endmodule

// File: rtl/coin_deposit.sv
// Customer credit accumulation, purchase into the bank and change return handshake.
// Purchase accounting lands on the edge that accepts vend_req, so VEND shows the results.
module coin_deposit
  import vm_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  coin_deposit_if.slave bus
);

  logic [1:0] state_r, state_s;
  money_t     credit_r, credit_s;
  money_t     bank_r, bank_s;
  money_t     change_r, change_s;
  logic       change_valid_r, change_valid_s;
  logic       vend_ok_r, vend_ok_s;
  logic       coin_reject_r, coin_reject_s;
  logic       redlight_r, redlight_s;

  money_t     coin_amt_s, credit_sum_s, bank_sum_s;
  logic       credit_ovf_s, bank_ovf_s, coin_ok_s;

  assign coin_amt_s = coin_value(bus.coin_type);
  assign coin_ok_s  = bus.coin_valid && !bus.mode && !credit_ovf_s;

  money_sat_add u_credit_add (.a(credit_r), .b(coin_amt_s), .sum(credit_sum_s), .ovf(credit_ovf_s));
  money_sat_add u_bank_add   (.a(bank_r),   .b(bus.price),  .sum(bank_sum_s),   .ovf(bank_ovf_s));

  // Next-state and next-output decode.
  always_comb begin
    state_s        = state_r;
    credit_s       = credit_r;
    bank_s         = bank_r;
    change_s       = change_r;
    change_valid_s = change_valid_r;
    vend_ok_s      = 1'b0;
    coin_reject_s  = 1'b0;
    redlight_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (coin_ok_s) begin
          credit_s = credit_sum_s;
          state_s  = ST_COLLECT;
        end else begin
          coin_reject_s = bus.coin_valid;
        end
      end
      ST_COLLECT: begin
        if (bus.cancel) begin
          coin_reject_s  = bus.coin_valid;
          change_s       = credit_r;
          change_valid_s = 1'b1;
          state_s        = ST_CHANGE;
        end else if (bus.vend_req && !bus.mode) begin
          coin_reject_s = bus.coin_valid;
          if ((bus.price > credit_r) || bank_ovf_s) begin
            redlight_s = 1'b1;
          end else begin
            bank_s    = bank_sum_s;
            vend_ok_s = 1'b1;
            change_s  = credit_r - bus.price;
            credit_s  = ZERO;
            state_s   = ST_VEND;
          end
        end else if (coin_ok_s) begin
          credit_s = credit_sum_s;
        end else begin
          coin_reject_s = bus.coin_valid;
        end
      end
      ST_VEND: begin
        coin_reject_s = bus.coin_valid;
        if (change_r != ZERO) begin
          change_valid_s = 1'b1;
          state_s        = ST_CHANGE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CHANGE: begin
        coin_reject_s = bus.coin_valid;
        if (change_valid_r && bus.change_ack) begin
          change_valid_s = 1'b0;
          change_s       = ZERO;
          credit_s       = ZERO;
          state_s        = ST_IDLE;
        end else begin
          state_s = ST_CHANGE;
        end
      end
      default: begin
        state_s        = ST_IDLE;
        credit_s       = ZERO;
        change_s       = ZERO;
        change_valid_s = 1'b0;
      end
    endcase
    // A purchase add in flight beats the owner's clear; the owner retries.
    if (bus.owner_take && bus.mode && (state_r != ST_VEND)) begin
      bank_s = ZERO;
    end else begin
      bank_s = bank_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      credit_r       <= ZERO;
      bank_r         <= ZERO;
      change_r       <= ZERO;
      change_valid_r <= 1'b0;
      vend_ok_r      <= 1'b0;
      coin_reject_r  <= 1'b0;
      redlight_r     <= 1'b0;
    end else begin
      state_r        <= state_s;
      credit_r       <= credit_s;
      bank_r         <= bank_s;
      change_r       <= change_s;
      change_valid_r <= change_valid_s;
      vend_ok_r      <= vend_ok_s;
      coin_reject_r  <= coin_reject_s;
      redlight_r     <= redlight_s;
    end
  end

  assign bus.credit        = credit_r;
  assign bus.machine_money = bank_r;
  assign bus.change        = change_r;
  assign bus.change_valid  = change_valid_r;
  assign bus.vend_ok       = vend_ok_r;
  assign bus.coin_reject   = coin_reject_r;
  assign bus.redlight      = redlight_r;

endmodule

// File: tb/tb_coin_deposit.sv
// Directed bench for coin_deposit; expected values are hand-computed per vector.
module tb_coin_deposit;
  import vm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks_cnt = 0;
  int   errors_cnt = 0;

  coin_deposit_if bus();
  coin_deposit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] t);
    bus.coin_valid = 1'b1;
    bus.coin_type  = t;
    tick();
    bus.coin_valid = 1'b0;
  endtask

  task automatic vend(input logic [10:0] p);
    bus.vend_req = 1'b1;
    bus.price    = p;
    tick();
    bus.vend_req = 1'b0;
  endtask

  task automatic do_cancel();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
  endtask

  task automatic ack();
    bus.change_ack = 1'b1;
    tick();
    bus.change_ack = 1'b0;
  endtask

  task automatic take();
    bus.owner_take = 1'b1;
    tick();
    bus.owner_take = 1'b0;
  endtask

  initial begin
    bus.mode = 1'b0; bus.coin_valid = 1'b0; bus.coin_type = 2'd0; bus.vend_req = 1'b0;
    bus.price = 11'd0; bus.cancel = 1'b0; bus.change_ack = 1'b0; bus.owner_take = 1'b0;
    tick(); tick();
    check_eq("rst_credit", bus.credit, 0);
    check_eq("rst_bank", bus.machine_money, 0);
    check_eq("rst_cv", bus.change_valid, 0);
    rst_n = 1'b1;
    tick();

    coin(2'd3); check_eq("t1_c25", bus.credit, 25);
    coin(2'd3); check_eq("t1_c50", bus.credit, 50);
    coin(2'd2); check_eq("t1_c60", bus.credit, 60);
    vend(11'd60);
    check_eq("t1_vok", bus.vend_ok, 1);
    check_eq("t1_bank", bus.machine_money, 60);
    check_eq("t1_credit", bus.credit, 0);
    tick();
    check_eq("t1_cv", bus.change_valid, 0);
    check_eq("t1_vok_pulse", bus.vend_ok, 0);

    coin(2'd3); coin(2'd3); coin(2'd2);
    vend(11'd45);
    check_eq("t2_vok", bus.vend_ok, 1);
    check_eq("t2_bank", bus.machine_money, 105);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t2_hold_cv", bus.change_valid, 1);
      check_eq("t2_hold_chg", bus.change, 15);
    end
    ack();
    check_eq("t2_ack_cv", bus.change_valid, 0);
    check_eq("t2_ack_chg", bus.change, 0);

    coin(2'd2);
    vend(11'd25);
    check_eq("t3_red", bus.redlight, 1);
    check_eq("t3_credit", bus.credit, 10);
    tick();
    check_eq("t3_red_pulse", bus.redlight, 0);
    do_cancel();
    check_eq("t3_cancel_chg", bus.change, 10);
    check_eq("t3_cancel_cv", bus.change_valid, 1);
    ack();
    check_eq("t3_credit_clr", bus.credit, 0);

    for (int i = 0; i < 81; i++) coin(2'd3);
    coin(2'd2); coin(2'd1);
    check_eq("t4_credit2040", bus.credit, 2040);
    coin(2'd2);
    check_eq("t4_coin_rej", bus.coin_reject, 1);
    check_eq("t4_credit_keep", bus.credit, 2040);
    vend(11'd1935);
    check_eq("t4_bank2040", bus.machine_money, 2040);
    check_eq("t4_chg105", bus.change, 105);
    tick(); ack();
    coin(2'd3);
    vend(11'd25);
    check_eq("t4_bank_red", bus.redlight, 1);
    check_eq("t4_bank_keep", bus.machine_money, 2040);
    check_eq("t4_credit25", bus.credit, 25);
    vend(11'd7);
    check_eq("t4_bank_max", bus.machine_money, 2047);
    check_eq("t4_chg18", bus.change, 18);
    tick(); ack();

    coin(2'd1);
    bus.mode = 1'b1;
    coin(2'd0);
    check_eq("t5_own_rej", bus.coin_reject, 1);
    check_eq("t5_own_credit", bus.credit, 5);
    vend(11'd5);
    check_eq("t5_own_novend", bus.vend_ok, 0);
    check_eq("t5_own_nored", bus.redlight, 0);
    take();
    check_eq("t5_take", bus.machine_money, 0);
    do_cancel();
    check_eq("t5_own_cancel", bus.change_valid, 1);
    check_eq("t5_own_chg", bus.change, 5);
    ack();
    bus.mode = 1'b0;
    coin(2'd1);
    vend(11'd5);
    check_eq("t5_bank5", bus.machine_money, 5);
    tick();
    check_eq("t5_nochg_cv", bus.change_valid, 0);
    take();
    check_eq("t5_take_cust", bus.machine_money, 5);

    coin(2'd2);
    bus.cancel = 1'b1;
    vend(11'd5);
    bus.cancel = 1'b0;
    check_eq("t6_cancel_wins_cv", bus.change_valid, 1);
    check_eq("t6_cancel_wins_chg", bus.change, 10);
    check_eq("t6_cancel_wins_vok", bus.vend_ok, 0);
    check_eq("t6_cancel_wins_bank", bus.machine_money, 5);
    ack();
    coin(2'd2);
    bus.coin_valid = 1'b1; bus.coin_type = 2'd3;
    vend(11'd10);
    bus.coin_valid = 1'b0;
    check_eq("t6_mix_rej", bus.coin_reject, 1);
    check_eq("t6_mix_vok", bus.vend_ok, 1);
    check_eq("t6_mix_bank", bus.machine_money, 15);
    check_eq("t6_mix_credit", bus.credit, 0);
    tick();
    coin(2'd2);
    do_cancel();
    check_eq("t6_pre_rst_cv", bus.change_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_arst_cv", bus.change_valid, 0);
    check_eq("t6_arst_chg", bus.change, 0);
    check_eq("t6_arst_credit", bus.credit, 0);
    check_eq("t6_arst_bank", bus.machine_money, 0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
